// File: rtl/run_reducer.sv
// Multi-lane run reducer: each lane drops the first DROP ones of every run of 1s and pulses run_done after the run ends.
// Optional macro RUN_REDUCER_STATS_EN builds the saturating drop_cnt statistics counter.
module run_reducer #(
  parameter int LANES = 4,
  parameter int DROP  = 1,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [LANES-1:0] in,
  output logic [LANES-1:0] out,
  output logic [LANES-1:0] run_done,
  output logic [15:0]      drop_cnt,
  input  logic             stats_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PASS    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  localparam logic [CNT_W:0]   DROP_C   = (CNT_W+1)'(DROP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             PASS_ALL = (DROP == 0);
  localparam logic             DIRECT   = (DROP <= 1);

  state_t           state_r    [LANES];
  logic [CNT_W-1:0] cnt_r      [LANES];
  logic [CNT_W:0]   cnt_inc_s  [LANES];
  logic [LANES-1:0] run_done_r;
  logic [LANES-1:0] out_s;
  logic [LANES-1:0] supp_s;

  // Mealy output, suppressed-one flags and counter increment per lane
  always_comb begin
    out_s  = '0;
    supp_s = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt_inc_s[i] = {1'b0, cnt_r[i]} + {{CNT_W{1'b0}}, 1'b1};
      if (reset || !en || !in[i]) begin
        out_s[i] = 1'b0;
      end else if (state_r[i] == PASS) begin
        out_s[i] = 1'b1;
      end else if (state_r[i] == ILLEGAL) begin
        out_s[i] = 1'b0;
      end else begin
        out_s[i] = PASS_ALL;
      end
      supp_s[i] = en & in[i] & ~out_s[i];
    end
  end

  // Per-lane run FSM and end-of-run pulse; with en=0 only run_done clears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        state_r[i] <= IDLE;
        cnt_r[i]   <= '0;
      end
      run_done_r <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        run_done_r[i] <= en & ~in[i] & (state_r[i] != IDLE);
        if (en) begin
          case (state_r[i])
            IDLE: begin
              if (in[i]) begin
                if (DIRECT) begin
                  state_r[i] <= PASS;
                end else begin
                  state_r[i] <= COUNT;
                  cnt_r[i]   <= CNT_ONE;
                end
              end
            end
            COUNT: begin
              if (in[i]) begin
                cnt_r[i] <= cnt_inc_s[i][CNT_W-1:0];
                if (cnt_inc_s[i] == DROP_C) begin
                  state_r[i] <= PASS;
                end
              end else begin
                state_r[i] <= IDLE;
                cnt_r[i]   <= '0;
              end
            end
            // cnt is frozen here so arbitrarily long runs never wrap
            PASS: begin
              if (!in[i]) begin
                state_r[i] <= IDLE;
                cnt_r[i]   <= '0;
              end
            end
            default: begin
              state_r[i] <= IDLE;
              cnt_r[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign out      = out_s;
  assign run_done = run_done_r;

`ifdef RUN_REDUCER_STATS_EN
  logic [15:0] drop_cnt_r;
  logic [16:0] drop_sum_s;

  function automatic logic [6:0] popcount(input logic [LANES-1:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < LANES; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  // Widened sum so saturation is a single carry test
  always_comb begin
    drop_sum_s = {1'b0, drop_cnt_r} + {10'd0, popcount(supp_s)};
  end

  // Saturating suppressed-ones counter; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_r <= 16'h0000;
    end else if (stats_clr) begin
      drop_cnt_r <= 16'h0000;
    end else if (drop_sum_s[16]) begin
      drop_cnt_r <= 16'hFFFF;
    end else begin
      drop_cnt_r <= drop_sum_s[15:0];
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  logic unused_stats_s;
  assign unused_stats_s = stats_clr | (|supp_s);
  assign drop_cnt       = 16'h0000;
`endif

endmodule

// File: tb/tb_run_reducer.sv
// Self-checking bench for run_reducer: vector table, hand-written corner sequences and
// randomized stimulus against a run-length reference model, across several DROP settings.
module tb_run_reducer;

  localparam int ND = 5;

  function automatic int drop_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      2:       return 2;
      3:       return 0;
      default: return 15;
    endcase
  endfunction

  logic                 clk;
  logic                 reset;
  logic                 en;
  logic                 stats_clr;
  logic [3:0]           in_v;
  logic [ND-1:0][3:0]   dut_out;
  logic [ND-1:0][3:0]   dut_rd;
  logic [ND-1:0][15:0]  dut_drop;
  logic [0:0]           out1;
  logic [0:0]           rd1;
  logic [15:0]          drop1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    run_reducer #(.LANES(4), .DROP(drop_of(g)), .CNT_W(4)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in        (in_v),
      .out       (dut_out[g]),
      .run_done  (dut_rd[g]),
      .drop_cnt  (dut_drop[g]),
      .stats_clr (stats_clr)
    );
  end

  run_reducer #(.LANES(1), .DROP(1), .CNT_W(4)) u_one (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in        (in_v[0]),
    .out       (out1),
    .run_done  (rd1),
    .drop_cnt  (drop1),
    .stats_clr (stats_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: length of the current run of 1s per lane (unbounded integer)
  int         run_len [ND][4];
  logic [3:0] rd_m    [ND];
  int         drop_m  [ND];
  int         drop1_m;
  int         tests;
  int         fails;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model_out(input int d);
    logic [3:0] r;
    r = 4'b0000;
    for (int l = 0; l < 4; l++) begin
      r[l] = !reset && en && in_v[l] && (run_len[d][l] >= drop_of(d));
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int l = 0; l < 4; l++) run_len[d][l] = 0;
      rd_m[d]   = 4'b0000;
      drop_m[d] = 0;
    end
    drop1_m = 0;
  endtask

  task automatic model_step();
    int         supp;
    logic [3:0] o;
    for (int d = 0; d < ND; d++) begin
      supp = 0;
      o    = model_out(d);
      for (int l = 0; l < 4; l++) begin
        if (en && in_v[l] && !o[l]) supp++;
        rd_m[d][l] = en && !in_v[l] && (run_len[d][l] > 0);
        if (en) run_len[d][l] = in_v[l] ? run_len[d][l] + 1 : 0;
      end
`ifdef RUN_REDUCER_STATS_EN
      if (stats_clr) drop_m[d] = 0;
      else drop_m[d] = (drop_m[d] + supp > 65535) ? 65535 : drop_m[d] + supp;
      if (d == 0) begin
        if (stats_clr) drop1_m = 0;
        else if (en && in_v[0] && !o[0] && drop1_m < 65535) drop1_m++;
      end
`endif
    end
  endtask

  task automatic check_all();
    logic [3:0] m;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("out_drop%0d", drop_of(d)), 16'(dut_out[d]), 16'(model_out(d)));
      chk($sformatf("run_done_drop%0d", drop_of(d)), 16'(dut_rd[d]), 16'(rd_m[d]));
      chk($sformatf("drop_cnt_drop%0d", drop_of(d)), dut_drop[d], 16'(drop_m[d]));
    end
    m = model_out(0);
    chk("out_single_lane", 16'(out1), 16'(m[0]));
    chk("run_done_single_lane", 16'(rd1), 16'(rd_m[0][0]));
    chk("drop_cnt_single_lane", drop1, 16'(drop1_m));
  endtask

  task automatic drive(input logic e, input logic [3:0] v, input logic clr);
    en        = e;
    in_v      = v;
    stats_clr = clr;
    #1;
  endtask

  task automatic advance();
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cycle(input logic e, input logic [3:0] v, input logic clr);
    drive(e, v, clr);
    advance();
  endtask

  typedef struct packed {
    logic       en;
    logic [3:0] in;
    logic [3:0] o1;
    logic [3:0] o3;
    logic [3:0] rd;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  initial begin
    logic [3:0] cur;
    int         guard;

    tests = 0;
    fails = 0;
    // {en, in, out DROP=1, out DROP=3, run_done}
    tbl[0]  = {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = {1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = {1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = {1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[4]  = {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = {1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    tbl[6]  = {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    tbl[8]  = {1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = {1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[10] = {1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[11] = {1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    tbl[12] = {1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    tbl[13] = {1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    tbl[14] = {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[15] = {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    tbl[16] = {1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[17] = {1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0000};
    tbl[18] = {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0101};
    tbl[19] = {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1010};
    tbl[20] = {1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[21] = {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    reset = 1'b1; en = 1'b1; in_v = 4'b1111; stats_clr = 1'b0;
    model_reset();
    #2;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset_out_drop%0d", drop_of(d)), 16'(dut_out[d]), 16'h0000);
      chk($sformatf("reset_rd_drop%0d", drop_of(d)), 16'(dut_rd[d]), 16'h0000);
      chk($sformatf("reset_cnt_drop%0d", drop_of(d)), dut_drop[d], 16'h0000);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].en, tbl[k].in, 1'b0);
      chk($sformatf("tbl%0d_out_d1", k), 16'(dut_out[0]), 16'(tbl[k].o1));
      chk($sformatf("tbl%0d_out_d3", k), 16'(dut_out[1]), 16'(tbl[k].o3));
      chk($sformatf("tbl%0d_rd_d1", k), 16'(dut_rd[0]), 16'(tbl[k].rd));
      chk($sformatf("tbl%0d_rd_d3", k), 16'(dut_rd[1]), 16'(tbl[k].rd));
      advance();
    end

    // DROP=2: pause with en=0 after two ones; first one after resume passes
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 4'b0001, 1'b0);
      chk("en_pause_lead", 16'(dut_out[2][0]), 16'h0000);
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'b0001, 1'b0);
      chk("en_pause_hold_out", 16'(dut_out[2]), 16'h0000);
      chk("en_pause_hold_rd", 16'(dut_rd[2]), 16'h0000);
      advance();
    end
    drive(1'b1, 4'b0001, 1'b0);
    chk("en_pause_resume", 16'(dut_out[2][0]), 16'h0001);
    advance();
    cycle(1'b1, 4'b0000, 1'b0);
    drive(1'b1, 4'b0000, 1'b0);
    chk("en_pause_run_done", 16'(dut_rd[2]), 16'h0001);
    advance();

    // Asynchronous reset in the middle of a passing run
    cycle(1'b1, 4'b1111, 1'b0);
    cycle(1'b1, 4'b1111, 1'b0);
    drive(1'b1, 4'b1111, 1'b0);
    chk("pre_reset_pass", 16'(dut_out[2]), 16'h000F);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_out_d2", 16'(dut_out[2]), 16'h0000);
    chk("async_reset_out_d0", 16'(dut_out[3]), 16'h0000);
    chk("async_reset_rd", 16'(dut_rd[2]), 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_held_rd", 16'(dut_rd[2]), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 4'b0000, 1'b0);
    drive(1'b1, 4'b1111, 1'b0);
    chk("post_reset_no_rd", 16'(dut_rd[2]), 16'h0000);
    chk("post_reset_sup1", 16'(dut_out[2]), 16'h0000);
    advance();
    drive(1'b1, 4'b1111, 1'b0);
    chk("post_reset_sup2", 16'(dut_out[2]), 16'h0000);
    advance();
    drive(1'b1, 4'b1111, 1'b0);
    chk("post_reset_pass", 16'(dut_out[2]), 16'h000F);
    advance();
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);

`ifdef RUN_REDUCER_STATS_EN
    cycle(1'b1, 4'b0000, 1'b1);
    cycle(1'b1, 4'b1111, 1'b0);
    cycle(1'b1, 4'b1010, 1'b0);
    drive(1'b1, 4'b0000, 1'b0);
    chk("stats_four_lanes", dut_drop[0], 16'h0004);
    advance();
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b1111, 1'b1);
    drive(1'b1, 4'b0000, 1'b0);
    chk("stats_clr_priority", dut_drop[0], 16'h0000);
    advance();
    guard = 0;
    while (drop_m[4] < 65535 && guard < 20000) begin
      cycle(1'b1, (guard % 16 == 15) ? 4'b0000 : 4'b1111, 1'b0);
      guard++;
    end
    chk("saturation_reached", 16'(guard < 20000), 16'h0001);
    for (int k = 0; k < 20; k++) cycle(1'b1, (k % 4 == 3) ? 4'b0000 : 4'b1111, 1'b0);
    drive(1'b1, 4'b0000, 1'b0);
    chk("stats_saturated", dut_drop[4], 16'hFFFF);
    advance();
    cycle(1'b1, 4'b0000, 1'b1);
`else
    cycle(1'b1, 4'b1111, 1'b1);
    drive(1'b1, 4'b0000, 1'b0);
    chk("stats_disabled_zero", dut_drop[0], 16'h0000);
    advance();
`endif

    // Randomized traffic with long-ish runs so DROP=15 is reached
    cur = 4'b0000;
    for (int k = 0; k < 2000; k++) begin
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(99) < 12) cur[l] = ~cur[l];
      end
      cycle($urandom_range(99) < 85, cur, $urandom_range(99) < 3);
    end
    cycle(1'b1, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
